// File: rtl/softmax_seq_pkg.sv
// Shared types and constants for the row-wise softmax sequencer and its core stand-in.
// Holds the FSM encoding, FP32 constants and the flat-bus index helper.
package softmax_seq_pkg;

  localparam int FP_W = 32;

  localparam logic [FP_W-1:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_HALF    = 32'h3F00_0000;
  localparam logic [FP_W-1:0] FP_THIRD   = 32'h3EAA_AAAB;
  localparam logic [FP_W-1:0] FP_QUARTER = 32'h3E80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_FEED,
    ST_WAIT,
    ST_NEXT,
    ST_ABORT,
    ST_DONE
  } seq_state_t;

  // Bit offset of element (r,c) in a row-major flat bus of FP32 words.
  function automatic int flat_lsb(input int r, input int c, input int cols);
    return (r * cols + c) * FP_W;
  endfunction

  // Maps an FP32 pattern onto an unsigned key with the same ordering as the real value.
  function automatic logic [FP_W-1:0] fp_order_key(input logic [FP_W-1:0] v);
    return v[FP_W-1] ? ~v : (v | 32'h8000_0000);
  endfunction

  function automatic logic [FP_W-1:0] fp_recip_count(input logic [2:0] k);
    logic [FP_W-1:0] r;
    case (k)
      3'd1:    r = FP_ONE;
      3'd2:    r = FP_HALF;
      3'd3:    r = FP_THIRD;
      3'd4:    r = FP_QUARTER;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/softmax_stub.sv
// Stand-in for the softmax core: hard-max softmax (ties share 1/k) with a fixed Done latency.
// HANG suppresses Done entirely so the sequencer watchdog can be exercised.
module softmax_stub
  import softmax_seq_pkg::*;
#(
  parameter int LAT  = 2,
  parameter bit HANG = 1'b0
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic [FP_W-1:0] Datain,
  input  logic [1:0]      N,
  output logic [FP_W-1:0] Y0,
  output logic [FP_W-1:0] Y1,
  output logic [FP_W-1:0] Y2,
  output logic [FP_W-1:0] Y3,
  output logic            Done
);

  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [FP_W-1:0] samp_q [4];
  logic [1:0]      cnt;
  logic [1:0]      n_q;
  logic            collecting;
  logic            pend;
  logic [LW-1:0]   dly;

  logic [FP_W-1:0] max_key;
  logic [2:0]      n_max;
  logic [FP_W-1:0] y_next [4];

  always_comb begin
    max_key = '0;
    n_max   = '0;
    y_next  = '{default: '0};
    for (int i = 0; i < 4; i++) begin
      if (i <= int'(n_q) && fp_order_key(samp_q[i]) > max_key) begin
        max_key = fp_order_key(samp_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i <= int'(n_q) && fp_order_key(samp_q[i]) == max_key) begin
        n_max = n_max + 3'd1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i <= int'(n_q) && fp_order_key(samp_q[i]) == max_key) begin
        y_next[i] = fp_recip_count(n_max);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      samp_q     <= '{default: '0};
      cnt        <= '0;
      n_q        <= '0;
      collecting <= 1'b0;
      pend       <= 1'b0;
      dly        <= '0;
      Done       <= 1'b0;
      Y0         <= '0;
      Y1         <= '0;
      Y2         <= '0;
      Y3         <= '0;
    end else begin
      Done <= 1'b0;
      if (Start) begin
        collecting <= 1'b1;
        cnt        <= '0;
        n_q        <= N;
        pend       <= 1'b0;
      end else if (collecting) begin
        samp_q[cnt] <= Datain;
        cnt         <= cnt + 2'd1;
        if (cnt == n_q) begin
          collecting <= 1'b0;
          pend       <= !HANG;
          dly        <= '0;
        end
      end else if (pend) begin
        if (dly == LW'(LAT - 1)) begin
          pend <= 1'b0;
          Done <= 1'b1;
          Y0   <= y_next[0];
          Y1   <= y_next[1];
          Y2   <= y_next[2];
          Y3   <= y_next[3];
        end else begin
          dly <= dly + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/softmax_rowwise_seq.sv
// Row-wise softmax sequencer: snapshots the matrix at start, streams each active row
// through one shared core, and collects normalised rows into a zero-padded output bank.
module softmax_rowwise_seq
  import softmax_seq_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int TIMEOUT   = 256,
  parameter int CORE_LAT  = 2,
  parameter bit CORE_HANG = 1'b0,
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [RW-1:0]             cfg_rows,
  input  logic [1:0]                cfg_cols,
  input  logic [ROWS*COLS*FP_W-1:0] x_flat,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      row_done,
  output logic [RW-1:0]             row_idx,
  output logic [ROWS*COLS*FP_W-1:0] y_flat
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  seq_state_t                st;
  logic [ROWS*COLS*FP_W-1:0] snap;
  logic [RW-1:0]             rows_q;
  logic [1:0]                cols_q;
  logic [RW-1:0]             row;
  logic [1:0]                col;
  logic [WCW-1:0]            wcnt;

  logic [RW-1:0]   rows_clamped;
  logic [1:0]      cols_clamped;
  logic            core_reset;
  logic            core_start;
  logic [FP_W-1:0] core_din;
  logic            core_done;
  logic [FP_W-1:0] core_y [4];

  always_comb begin
    rows_clamped = cfg_rows;
    cols_clamped = cfg_cols;
    if ({{(32-RW){1'b0}}, cfg_rows} >= 32'(ROWS)) rows_clamped = RW'(ROWS - 1);
    if ({30'b0, cfg_cols} >= 32'(COLS)) cols_clamped = 2'(COLS - 1);
  end

  // The core is also cleared during ABORT so a hung row cannot leak into the next run.
  assign core_reset = rst | (st == ST_ABORT);
  assign core_start = (st == ST_PULSE);

  always_comb begin
    core_din = '0;
    if (st == ST_FEED) core_din = snap[flat_lsb(int'(row), int'(col), COLS) +: FP_W];
  end

  softmax_stub #(
    .LAT  (CORE_LAT),
    .HANG (CORE_HANG)
  ) u_core (
    .Clock  (clk),
    .Reset  (core_reset),
    .Start  (core_start),
    .Datain (core_din),
    .N      (cols_q),
    .Y0     (core_y[0]),
    .Y1     (core_y[1]),
    .Y2     (core_y[2]),
    .Y3     (core_y[3]),
    .Done   (core_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      snap     <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      row      <= '0;
      col      <= '0;
      wcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      row_done <= 1'b0;
      row_idx  <= '0;
      y_flat   <= '0;
    end else begin
      done     <= 1'b0;
      row_done <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (start) begin
            snap   <= x_flat;
            rows_q <= rows_clamped;
            cols_q <= cols_clamped;
            y_flat <= '0;
            err    <= 1'b0;
            row    <= '0;
            busy   <= 1'b1;
            st     <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          col <= '0;
          st  <= ST_FEED;
        end
        ST_FEED: begin
          col <= col + 2'd1;
          if (col == cols_q) begin
            wcnt <= '0;
            st   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wcnt <= wcnt + 1'b1;
          // Done on the final allowed cycle still wins over the watchdog.
          if (core_done) begin
            for (int c = 0; c < COLS; c++) begin
              if (c <= int'(cols_q)) y_flat[flat_lsb(int'(row), c, COLS) +: FP_W] <= core_y[c];
            end
            row_done <= 1'b1;
            row_idx  <= row;
            st       <= ST_NEXT;
          end else if (wcnt == WCW'(TIMEOUT - 1)) begin
            st <= ST_ABORT;
          end
        end
        ST_NEXT: begin
          if (row == rows_q) begin
            done <= 1'b1;
            busy <= 1'b0;
            st   <= ST_DONE;
          end else begin
            row <= row + 1'b1;
            st  <= ST_PULSE;
          end
        end
        ST_ABORT: begin
          err  <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          st   <= ST_DONE;
        end
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/softmax_rowwise_seq.md
# softmax_rowwise_seq

Parametrised row-wise softmax sequencer for an ROWS x COLS FP32 matrix. It snapshots the matrix at `start`, streams each active row through one shared `softmax` core, and writes normalised rows to an output bank. Over the fixed 4x4 sequencer it adds:
- runtime row and column counts, with zero padding of inactive columns;
- input snapshotting;
- busy, per-row done and error reporting;
- a core watchdog with abort.

It sits between the score-matrix stage and the attention-weight consumer.

## Interface
- `ROWS`, default 4, matrix rows, 1..16.
- `COLS`, default 4, matrix columns, 1..4 (core output width).
- `TIMEOUT`, default 256, maximum WAIT cycles per row before abort, ≥ 8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; accepted only when `busy`=0.
- `cfg_rows` in RW=max(1,$clog2(ROWS)): active rows minus 1; values ≥ ROWS clamp to ROWS-1.
- `cfg_cols` in 2: active columns minus 1; values ≥ COLS clamp to COLS-1.
- `x_flat` in ROWS*COLS*32: FP32 inputs; element (r,c) at bits [(r*COLS+c)*32 +: 32].
- `busy` out 1: high from the cycle after accept until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: watchdog abort flag; held until the next accepted start.
- `row_done` out 1: one-cycle pulse per completed row.
- `row_idx` out RW: row of the current `row_done`.
- `y_flat` out ROWS*COLS*32: results, same layout as `x_flat`.

## Operation
- **States:** IDLE, PULSE, FEED, WAIT, NEXT, ABORT, DONE.
- **IDLE:**
  - On `start`: latch `x_flat` into the snapshot bank and latch clamped `cfg_rows`/`cfg_cols`.
  - Clear all of `y_flat` and `err`; set row=0; go to PULSE.
- **PULSE:** core `Start`=1; col=0; go to FEED.
- **FEED:**
  - Core `Datain` = snapshot(row,col); col increments each cycle.
  - Lasts cfg_cols+1 cycles, then go to WAIT.
- **Core `N`:** held at cfg_cols for the whole row.
- **WAIT:**
  - Wait counter increments each cycle.
  - On core `Done`: capture `Y0..Y(cfg_cols)` into row `row` of `y_flat`; columns above cfg_cols stay 0; go to NEXT.
  - If the counter reaches TIMEOUT with no `Done`: go to ABORT.
- **NEXT:**
  - `row_done`=1 and `row_idx`=row.
  - If row==cfg_rows, go to DONE; else row+1 and go to PULSE.
- **ABORT:**
  - Core `Reset`=1 for one cycle; `err`<=1.
  - Rows not yet captured remain 0; go to DONE.
- **DONE:** `done`=1 for one cycle; go to IDLE.
- **Core reset:** core `Reset` = `rst` OR (state==ABORT).
- **Input isolation:** changes on `x_flat`, `cfg_rows` or `cfg_cols` after accept have no effect on the run in progress.
- **`start` while busy:** ignored, including in DONE; no queueing.

## Timing
- **Reset values:** all outputs 0, state IDLE, snapshot bank 0.
- **Reset mid-operation:** returns to IDLE the next edge; partial results are discarded (cleared).
- **Accept:** `start` sampled in IDLE at edge k → PULSE during cycle k+1, `busy`=1 from k+1.
- **Per-row latency:** 1 (PULSE) + (cfg_cols+1) (FEED) + W (WAIT, W ≥ 1, cycle holding `Done` included) + 1 (NEXT).
- **Output update:** `y_flat` row updates on the edge ending the `Done` cycle and is visible in NEXT with `row_done`.
- **Completion:** `done` is asserted the cycle after the last NEXT (or after ABORT); `busy` drops together with `done`, so the next `start` is accepted from the following cycle.
- **`Done` on the timeout cycle:** `Done` wins; the row is captured.
- **Core `Done` outside WAIT:** ignored.

## Structure
- **Package `softmax_seq_pkg`:**
  - state enum encoding;
  - `FP_W`=32;
  - `FP_ONE`=32'h3F800000, `FP_HALF`=32'h3F000000, `FP_QUARTER`=32'h3E800000;
  - helper for flat-bus index math.
- **Sub-module:** the existing `softmax` core (Clock, Reset, Start, Datain, N, Y0..Y3, Done), instantiated once.
- **Sequencer:** the snapshot bank and FSM stay in this module.
- **Bench stub:** provide `softmax_stub` with programmable `Done` latency and a never-Done mode, for watchdog tests.

## Test plan
1. **Full 4x4, all 1.0:** ROWS=COLS=4, cfg 3/3, all inputs 1.0 → every Y = 3E800000 (±2 ULP), 4 `row_done` pulses with `row_idx` 0..3, then a single `done`, `err`=0.
2. **Reduced columns and rows:** cfg_cols=1, row = [0.0, 0.0, 5.0, 5.0], cfg_rows=0 → Y00=Y01=3F000000, Y02=Y03=0, rows 1..3 = 0, exactly one `row_done`.
3. **Snapshot isolation:** change all of `x_flat` to 2.0 one cycle after accept → results match the pre-change inputs; a `start` pulsed mid-run does not restart the run and does not produce a second `done`.
4. **Watchdog abort:** stub never asserts `Done`, TIMEOUT=16 → ABORT after 16 WAIT cycles, core `Reset` pulse, `err`=1, `done` pulse, `y_flat` all 0; the next start clears `err`.
5. **Reset mid-run and clamping:** assert `rst` during row 2 FEED → next cycle all outputs 0, IDLE; a re-start with cfg_cols=3 on a COLS=2 build clamps to 2 columns.
